mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified instruction/data memory between IF-stage fetch and MEM-stage load/store.
//  Grants one requester at a time and issues the access.
//  Times the fixed memory latency, then returns data with a one-cycle ready pulse.
//  Drives stall_if/stall_mem into the hazard logic (gates pc_write, if_id_write and the EX/MEM latch).
// PARAMETERS
//  ADDR_W       32  byte-address width
//  DATA_W       32  word width
//  MEM_LATENCY  2   cycles from port_en issue to port_rdata valid; legal range 1..15
// PORTS
//  clock      in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  if_req     in   1       fetch request; held with if_addr until if_ready
//  if_addr    in   ADDR_W  fetch byte address (cur_pc)
//  if_rdata   out  DATA_W  fetched instruction; valid when if_ready=1
//  if_ready   out  1       one-cycle completion pulse for fetch
//  mem_req    in   1       data request (mem_read|mem_write of EX/MEM); held until mem_ready
//  mem_we     in   1       1=store, 0=load; stable while mem_req=1
//  mem_addr   in   ADDR_W  data byte address (result_ex_mem)
//  mem_wdata  in   DATA_W  store data (wdata_mem)
//  mem_rdata  out  DATA_W  load data; valid when mem_ready=1
//  mem_ready  out  1       one-cycle completion pulse for data access
//  port_en    out  1       memory access strobe, one cycle per access
//  port_we    out  1       memory write enable, qualified by port_en
//  port_addr  out  ADDR_W  memory address, bits [1:0] forced 0
//  port_wdata out  DATA_W  memory write data
//  port_rdata in   DATA_W  memory read data, valid MEM_LATENCY cycles after port_en
//  stall_if   out  1       if_req & ~if_ready (combinational)
//  stall_mem  out  1       mem_req & ~mem_ready (combinational)
//  busy       out  1       1 while state != IDLE
// BEHAVIOUR
//  Reset values: all registered outputs 0 (port_en, port_we, port_addr, port_wdata, if_/mem_rdata, *_ready);
//   state=IDLE, lat_cnt=0, last_grant=IF.
//  States:
//   - IDLE: no req -> IDLE.
//     One req -> ISSUE_<src>.
//     Both reqs -> round-robin: grant the source not in last_grant (after reset, MEM wins first).
//   - ISSUE_IF/ISSUE_MEM: port_en=1 for exactly one cycle; addr/we/wdata registered from the winner.
//     The IF grant forces port_we=0. lat_cnt loaded with MEM_LATENCY-1. Next state WAIT.
//   - WAIT: decrement lat_cnt each cycle. When lat_cnt==0: capture port_rdata into the winner's rdata,
//     pulse the winner's ready for 1 cycle, update last_grant, go to IDLE.
//  Latency: req seen in IDLE at cycle N -> port_en at N+1 -> ready at N+1+MEM_LATENCY.
//   The loser keeps waiting; it is served after the winner completes.
//  Stores: also wait MEM_LATENCY; mem_rdata is updated with port_rdata (don't-care for stores).
//  A requester still asserting req in the cycle after its ready pulse is a NEW request.
//  Requests sampled only in IDLE; deassertion mid-access does not cancel it (result still delivered).
//  rdata holds its last value until the next completion for that source.
//  port_wdata holds its value except when issuing a store.
//  Reset mid-access: immediate return to IDLE, ready suppressed; the in-flight port_rdata is discarded.
//  Simultaneous ready for both sources is impossible; the bench asserts it never occurs.
// STRUCTURE
//  mips_pkg: state encodings (ARB_IDLE, ARB_ISSUE_IF, ARB_ISSUE_MEM, ARB_WAIT), SRC_IF/SRC_MEM constants,
//   default MEM_LATENCY.
//  Sub-module rr_pick2: 2-way round-robin picker (req[1:0], last_grant -> grant).
//   Purely combinational, reusable for the future register-file write-port share.
//  lat_cnt is 4 bits wide; elaboration error if MEM_LATENCY is outside 1..15.
// TESTING
//  1. Fetch only: if_req=1, if_addr=0x0000_0040, port_rdata=0x2008_0005.
//     Expect port_en pulse with port_addr=0x40 one cycle later; if_ready with if_rdata=0x2008_0005 2 cycles later.
//  2. Store: mem_req=1, mem_we=1, mem_addr=0x103, mem_wdata=0xDEAD_BEEF.
//     Expect port_en=1, port_we=1, port_addr=0x100, port_wdata=0xDEAD_BEEF; mem_ready at N+3.
//  3. Contention: if_req and mem_req rise together after reset.
//     Expect MEM served first and IF next; stall_if high the entire 6 cycles until its ready.
//  4. Back-to-back fetches: if_req held 3 accesses.
//     Expect 3 if_ready pulses exactly 3 cycles apart (idle + issue + latency), with correct data each.
//  5. Reset during WAIT of a load.
//     Expect no mem_ready; busy=0 and all outputs 0 immediately; next request completes normally.
//  6. MEM_LATENCY=1 and 15 builds: verify ready at N+2 and N+16; assert if_ready & mem_ready never both 1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared types and constants for the unified memory-port
//                arbiter: FSM state encoding, requester source IDs and the
//                default memory latency.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE_IF  = 2'd1,
    ARB_ISSUE_MEM = 2'd2,
    ARB_WAIT      = 2'd3
  } arb_state_e;

  // Requester identifiers; also the bit index into the picker request vector
  localparam logic SRC_IF  = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  localparam int DEF_MEM_LATENCY = 2;
  localparam int LAT_W           = 4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Two-way round-robin picker, purely combinational.
//                A lone request is granted directly; when both request, the
//                source that did not win last time is granted.
//  Ports       : req_i[1:0]   request vector (bit 0 = IF, bit 1 = MEM)
//                last_grant_i source index of the previous winner
//                grant_o[1:0] one-hot grant, all zero when idle
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port instruction/data memory between the
//                IF-stage fetch and the MEM-stage load/store. One access is
//                in flight at a time; the fixed memory latency is timed and
//                the result is returned with a one-cycle ready pulse.
//  Ports       : clock_i / reset_i        clock, async active-high reset
//                if_req_i, if_addr_i      fetch request and byte address
//                if_rdata_o, if_ready_o   fetched word and completion pulse
//                mem_req_i, mem_we_i,     data request, store flag,
//                mem_addr_i, mem_wdata_i  address and store data
//                mem_rdata_o, mem_ready_o load data and completion pulse
//                port_*                   memory-side access port
//                stall_if_o, stall_mem_o  hazard-unit stall requests
//                busy_o                   access in progress
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ready_o,
  output logic              port_en_o,
  output logic              port_we_o,
  output logic [ADDR_W-1:0] port_addr_o,
  output logic [DATA_W-1:0] port_wdata_o,
  input  logic [DATA_W-1:0] port_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o,
  output logic              busy_o
);

  if ((MEM_LATENCY < 1) || (MEM_LATENCY > 15)) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must lie in 1..15");
  end

  // Counter value loaded on issue; completion happens on the edge where
  // the counter is already zero, giving ready MEM_LATENCY cycles after port_en.
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);

  arb_state_e        state_q,      state_d;
  logic [LAT_W-1:0]  lat_cnt_q,    lat_cnt_d;
  logic              src_q,        src_d;
  logic              last_grant_q, last_grant_d;
  logic              port_en_q,    port_en_d;
  logic              port_we_q,    port_we_d;
  logic [ADDR_W-1:0] port_addr_q,  port_addr_d;
  logic [DATA_W-1:0] port_wdata_q, port_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q,  mem_rdata_d;
  logic              if_ready_q,   if_ready_d;
  logic              mem_ready_q,  mem_ready_d;

  logic [1:0]        w_grant;
  logic              w_unused;

  // Byte-lane bits are dropped: the memory is word addressed.
  assign w_unused = ^{if_addr_i[1:0], mem_addr_i[1:0]};

  rr_pick2 u_pick (
    .req_i        ({mem_req_i, if_req_i}),
    .last_grant_i (last_grant_q),
    .grant_o      (w_grant)
  );

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    port_en_d    = 1'b0;
    port_we_d    = 1'b0;
    port_addr_d  = port_addr_q;
    port_wdata_d = port_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // The port strobe and address are registered on entry to ISSUE so
        // they are visible for exactly the ISSUE cycle.
        if (w_grant[SRC_MEM]) begin
          state_d     = ARB_ISSUE_MEM;
          src_d       = SRC_MEM;
          lat_cnt_d   = LAT_INIT;
          port_en_d   = 1'b1;
          port_we_d   = mem_we_i;
          port_addr_d = {mem_addr_i[ADDR_W-1:2], 2'b00};
          if (mem_we_i) begin
            port_wdata_d = mem_wdata_i;
          end
        end else if (w_grant[SRC_IF]) begin
          state_d     = ARB_ISSUE_IF;
          src_d       = SRC_IF;
          lat_cnt_d   = LAT_INIT;
          port_en_d   = 1'b1;
          port_addr_d = {if_addr_i[ADDR_W-1:2], 2'b00};
        end
      end

      ARB_ISSUE_IF, ARB_ISSUE_MEM, ARB_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d      = ARB_IDLE;
          last_grant_d = src_q;
          if (src_q == SRC_MEM) begin
            mem_rdata_d = port_rdata_i;
            mem_ready_d = 1'b1;
          end else begin
            if_rdata_d = port_rdata_i;
            if_ready_d = 1'b1;
          end
        end else begin
          state_d   = ARB_WAIT;
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ARB_IDLE;
      lat_cnt_q    <= '0;
      src_q        <= SRC_IF;
      last_grant_q <= SRC_IF;
      port_en_q    <= 1'b0;
      port_we_q    <= 1'b0;
      port_addr_q  <= '0;
      port_wdata_q <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      port_en_q    <= port_en_d;
      port_we_q    <= port_we_d;
      port_addr_q  <= port_addr_d;
      port_wdata_q <= port_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
    end
  end

  assign port_en_o    = port_en_q;
  assign port_we_o    = port_we_q;
  assign port_addr_o  = port_addr_q;
  assign port_wdata_o = port_wdata_q;
  assign if_rdata_o   = if_rdata_q;
  assign if_ready_o   = if_ready_q;
  assign mem_rdata_o  = mem_rdata_q;
  assign mem_ready_o  = mem_ready_q;
  assign stall_if_o   = if_req_i & ~if_ready_q;
  assign stall_mem_o  = mem_req_i & ~mem_ready_q;
  assign busy_o       = (state_q != ARB_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Bench for mem_port_arbiter. Three instances with latencies
//                2, 1 and 15 share the requester inputs; each has its own
//                memory and a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int NI = 3;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  // Initial memory image; word 16 (byte 0x40) holds the fetch-test opcode.
  function automatic logic [31:0] mem_init(input int k);
    if (k == 16) return 32'h2008_0005;
    return 32'hC0DE_0000 ^ (32'(k) * 32'h0001_0101);
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;

  logic [31:0] if_rdata [NI];
  logic [31:0] mem_rdata [NI];
  logic [31:0] port_addr [NI];
  logic [31:0] port_wdata [NI];
  logic [31:0] port_rdata [NI];
  logic        if_ready [NI];
  logic        mem_ready [NI];
  logic        port_en [NI];
  logic        port_we [NI];
  logic        stall_if [NI];
  logic        stall_mem [NI];
  logic        busy [NI];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s [lat=%0d]: observed %0h expected %0h", tag, lat_of(id), obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_fail++;
    $error("FAIL %s: observed timeout expected completion", tag);
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) u_dut (
      .clock_i      (clk),
      .reset_i      (rst),
      .if_req_i     (if_req),
      .if_addr_i    (if_addr),
      .if_rdata_o   (if_rdata[g]),
      .if_ready_o   (if_ready[g]),
      .mem_req_i    (mem_req),
      .mem_we_i     (mem_we),
      .mem_addr_i   (mem_addr),
      .mem_wdata_i  (mem_wdata),
      .mem_rdata_o  (mem_rdata[g]),
      .mem_ready_o  (mem_ready[g]),
      .port_en_o    (port_en[g]),
      .port_we_o    (port_we[g]),
      .port_addr_o  (port_addr[g]),
      .port_wdata_o (port_wdata[g]),
      .port_rdata_i (port_rdata[g]),
      .stall_if_o   (stall_if[g]),
      .stall_mem_o  (stall_mem[g]),
      .busy_o       (busy[g])
    );

    // Memory: read data appears with the strobe and is held until the next access.
    logic [31:0] memv [256];
    logic [31:0] rd_hold = 32'h0;

    initial for (int k = 0; k < 256; k++) memv[k] <= mem_init(k);

    assign port_rdata[g] = port_en[g] ? memv[port_addr[g][9:2]] : rd_hold;

    always @(posedge clk) begin
      if (port_en[g]) begin
        rd_hold <= memv[port_addr[g][9:2]];
        if (port_we[g]) memv[port_addr[g][9:2]] <= port_wdata[g];
      end
    end

    // Reference model: an access granted at cycle N finishes L cycles after its strobe.
    int          rem;
    logic        msrc, mlast;
    logic [31:0] mpend;
    logic        e_en, e_we, e_ifr, e_memr, e_busy;
    logic [31:0] e_addr, e_wdata, e_ifd, e_memd;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        rem <= 0; msrc <= 1'b0; mlast <= 1'b0; mpend <= '0;
        e_en <= 1'b0; e_we <= 1'b0; e_ifr <= 1'b0; e_memr <= 1'b0; e_busy <= 1'b0;
        e_addr <= '0; e_wdata <= '0; e_ifd <= '0; e_memd <= '0;
      end else begin
        e_en   <= 1'b0;
        e_we   <= 1'b0;
        e_ifr  <= 1'b0;
        e_memr <= 1'b0;
        if (rem == 0) begin
          if (mem_req && (!if_req || !mlast)) begin
            rem    <= L;
            msrc   <= 1'b1;
            e_busy <= 1'b1;
            e_en   <= 1'b1;
            e_we   <= mem_we;
            e_addr <= mem_addr & 32'hFFFF_FFFC;
            mpend  <= memv[mem_addr[9:2]];
            if (mem_we) e_wdata <= mem_wdata;
          end else if (if_req) begin
            rem    <= L;
            msrc   <= 1'b0;
            e_busy <= 1'b1;
            e_en   <= 1'b1;
            e_addr <= if_addr & 32'hFFFF_FFFC;
            mpend  <= memv[if_addr[9:2]];
          end
        end else begin
          rem <= rem - 1;
          if (rem == 1) begin
            e_busy <= 1'b0;
            mlast  <= msrc;
            if (msrc) begin e_memr <= 1'b1; e_memd <= mpend; end
            else      begin e_ifr  <= 1'b1; e_ifd  <= mpend; end
          end
        end
      end
    end

    always @(negedge clk) begin
      chk("port_en", g, 32'(port_en[g]), 32'(e_en));
      if (e_en) begin
        chk("port_addr", g, port_addr[g], e_addr);
        chk("port_we", g, 32'(port_we[g]), 32'(e_we));
      end
      chk("port_wdata", g, port_wdata[g], e_wdata);
      chk("busy", g, 32'(busy[g]), 32'(e_busy));
      chk("if_ready", g, 32'(if_ready[g]), 32'(e_ifr));
      chk("mem_ready", g, 32'(mem_ready[g]), 32'(e_memr));
      chk("if_rdata", g, if_rdata[g], e_ifd);
      chk("mem_rdata", g, mem_rdata[g], e_memd);
      chk("stall_if", g, 32'(stall_if[g]), 32'(if_req & ~e_ifr));
      chk("stall_mem", g, 32'(stall_mem[g]), 32'(mem_req & ~e_memr));
      chk("both_ready", g, 32'(if_ready[g] & mem_ready[g]), 32'd0);
    end
  end

  // First-event records per instance, filled by collect().
  int          en_c [NI], ifr_c [NI], mr_c [NI];
  logic [31:0] a_c [NI], wd_c [NI], ifd_c [NI], md_c [NI];
  logic        we_c [NI];
  int          stall_cnt;

  task automatic collect(input bit need_if, input bit need_mem, input int maxc, input string tag);
    bit done;
    for (int i = 0; i < NI; i++) begin
      en_c[i] = -1; ifr_c[i] = -1; mr_c[i] = -1;
    end
    stall_cnt = 0;
    done = 1'b0;
    for (int k = 0; k < maxc && !done; k++) begin
      @(negedge clk);
      if (stall_if[0] && ifr_c[0] < 0) stall_cnt++;
      for (int i = 0; i < NI; i++) begin
        if (port_en[i] && en_c[i] < 0) begin
          en_c[i] = cyc; a_c[i] = port_addr[i]; we_c[i] = port_we[i]; wd_c[i] = port_wdata[i];
        end
        if (if_ready[i] && ifr_c[i] < 0) begin ifr_c[i] = cyc; ifd_c[i] = if_rdata[i]; end
        if (mem_ready[i] && mr_c[i] < 0) begin mr_c[i] = cyc; md_c[i] = mem_rdata[i]; end
      end
      done = 1'b1;
      for (int i = 0; i < NI; i++)
        if ((need_if && ifr_c[i] < 0) || (need_mem && mr_c[i] < 0)) done = 1'b0;
    end
    if (!done) timeout(tag);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 60 && !idle; k++) begin
      @(negedge clk);
      idle = 1'b1;
      for (int i = 0; i < NI; i++) if (busy[i]) idle = 1'b0;
    end
    if (!idle) timeout("wait_idle");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  int          N;
  int          bb_c [3];
  logic [31:0] bb_d [3];
  int          nb;

  initial begin
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_port_en", i, 32'(port_en[i]), 32'd0);
      chk("rst_port_addr", i, port_addr[i], 32'd0);
      chk("rst_if_rdata", i, if_rdata[i], 32'd0);
      chk("rst_mem_ready", i, 32'(mem_ready[i]), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Fetch only
    N = cyc; if_req = 1'b1; if_addr = 32'h0000_0040;
    collect(1'b1, 1'b0, 40, "t1_fetch");
    for (int i = 0; i < NI; i++) begin
      chk("t1_en_cycle", i, 32'(en_c[i] - N), 32'd1);
      chk("t1_port_addr", i, a_c[i], 32'h40);
      chk("t1_ready_cycle", i, 32'(ifr_c[i] - N), 32'(1 + lat_of(i)));
      chk("t1_if_rdata", i, ifd_c[i], 32'h2008_0005);
    end
    #1 if_req = 1'b0;
    wait_idle();

    // Store with unaligned address
    N = cyc; mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h103; mem_wdata = 32'hDEAD_BEEF;
    collect(1'b0, 1'b1, 40, "t2_store");
    for (int i = 0; i < NI; i++) begin
      chk("t2_en_cycle", i, 32'(en_c[i] - N), 32'd1);
      chk("t2_port_addr", i, a_c[i], 32'h100);
      chk("t2_port_we", i, 32'(we_c[i]), 32'd1);
      chk("t2_port_wdata", i, wd_c[i], 32'hDEAD_BEEF);
      chk("t2_ready_cycle", i, 32'(mr_c[i] - N), 32'(1 + lat_of(i)));
    end
    #1 begin mem_req = 1'b0; mem_we = 1'b0; end
    wait_idle();

    // Contention straight out of reset: MEM first, then IF
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    N = cyc; if_req = 1'b1; if_addr = 32'h24; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20;
    collect(1'b1, 1'b1, 80, "t3_contention");
    for (int i = 0; i < NI; i++) begin
      chk("t3_mem_ready_cycle", i, 32'(mr_c[i] - N), 32'(1 + lat_of(i)));
      chk("t3_if_ready_cycle", i, 32'(ifr_c[i] - N), 32'(2 + 2 * lat_of(i)));
      chk("t3_mem_rdata", i, md_c[i], mem_init(8));
      chk("t3_if_rdata", i, ifd_c[i], mem_init(9));
    end
    chk("t3_stall_if_cycles", 0, 32'(stall_cnt), 32'd6);
    #1 begin if_req = 1'b0; mem_req = 1'b0; end
    wait_idle();

    // Back-to-back fetches on the latency-2 instance
    if_req = 1'b1; if_addr = 32'h80; nb = 0;
    for (int k = 0; k < 30 && nb < 3; k++) begin
      @(negedge clk);
      if (if_ready[0]) begin
        bb_c[nb] = cyc; bb_d[nb] = if_rdata[0]; nb++;
        #1 if_addr = 32'h80 + 32'(4 * nb);
        if (nb == 3) if_req = 1'b0;
      end
    end
    if (nb < 3) timeout("t4_back_to_back");
    else begin
      chk("t4_gap1", 0, 32'(bb_c[1] - bb_c[0]), 32'd3);
      chk("t4_gap2", 0, 32'(bb_c[2] - bb_c[1]), 32'd3);
      for (int j = 0; j < 3; j++) chk("t4_if_rdata", 0, bb_d[j], mem_init(32 + j));
    end
    #1 if_req = 1'b0;
    wait_idle();

    // Reset while a load is waiting on the memory
    N = cyc; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h44;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("t5_busy", i, 32'(busy[i]), 32'd0);
      chk("t5_port_en", i, 32'(port_en[i]), 32'd0);
      chk("t5_mem_ready", i, 32'(mem_ready[i]), 32'd0);
      chk("t5_mem_rdata", i, mem_rdata[i], 32'd0);
      chk("t5_port_addr", i, port_addr[i], 32'd0);
    end
    mem_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("t5_no_mem_ready", 0, 32'(mem_ready[0]), 32'd0);
    end
    @(posedge clk); #1;
    N = cyc; mem_req = 1'b1; mem_addr = 32'h48;
    collect(1'b0, 1'b1, 40, "t5_after_reset");
    for (int i = 0; i < NI; i++) begin
      chk("t5_ready_cycle", i, 32'(mr_c[i] - N), 32'(1 + lat_of(i)));
      chk("t5_mem_rdata_new", i, md_c[i], mem_init(18));
    end
    #1 mem_req = 1'b0;
    wait_idle();

    // Random traffic, including rare asynchronous resets
    for (int k = 0; k < 400; k++) begin
      if_req    = ($urandom_range(0, 3) != 0);
      mem_req   = ($urandom_range(0, 2) == 0);
      mem_we    = $urandom_range(0, 1) == 1;
      if_addr   = $urandom & 32'h3FF;
      mem_addr  = $urandom & 32'h3FF;
      mem_wdata = $urandom;
      rst       = ($urandom_range(0, 150) == 0);
      @(posedge clk); #1;
      rst = 1'b0;
    end
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
